mem_io_controller: RTL and testbench
====================================

// Module: mem_io_controller
// PURPOSE
//  Parametrised memory/IO access controller between the CPU datapath (MAR/MDR) and the RAM macro.
//  Replaces the fixed single inport/outport with N_IN/N_OUT memory-mapped channels.
//  Adds a multi-cycle handshake (request -> out_ready) so the control unit stalls on slow RAM.
//  Instantiated in the system top between datapath, RAM and the external port pins.
// PARAMETERS
//  DATA_W      32      data word width
//  ADDR_W      9       address width (RAM depth 2**ADDR_W words, including IO window)
//  N_IN        2       number of input ports (1..16)
//  N_OUT       2       number of output ports (1..16)
//  MEM_LATENCY 1       RAM read latency in clocks, address-in to q-valid (1..7)
//  IO_BASE     9'h1F0  first address of the IO window; window is IO_BASE..IO_BASE+15
// PORTS
//  clk               in   1             system clock
//  reset             in   1             synchronous, active-high reset
//  in_rd             in   1             read request strobe, sampled only in IDLE
//  in_wr             in   1             write request strobe, sampled only in IDLE
//  in_addr           in   ADDR_W        request address (MAR)
//  in_wdata          in   DATA_W        write data (MDR)
//  out_rdata         out  DATA_W        read data, valid with out_ready, held until next read completes
//  out_ready         out  1             one-cycle completion pulse
//  out_err           out  1             one-cycle pulse with out_ready on an illegal request
//  out_busy          out  1             high in any state other than IDLE
//  out_mem_address   out  ADDR_W        RAM address (registered request address)
//  out_mem_data      out  DATA_W        RAM write data (registered)
//  out_mem_rden      out  1             RAM read enable
//  out_mem_wren      out  1             RAM write enable
//  in_mem_q          in   DATA_W        RAM read data
//  in_inport_data    in   N_IN*DATA_W   external input words; channel k = bits [k*DATA_W +: DATA_W]
//  in_inport_strobe  in   N_IN          per-channel capture enable
//  out_outport_data  out  N_OUT*DATA_W  output port registers, same packing
//  out_outport_valid out  N_OUT         one-cycle pulse on the cycle after channel k is written
// BEHAVIOUR
//  - Reset: state IDLE. All outputs 0, including out_rdata, all port registers and the inport capture registers.
//  - Reset mid-access: abandons the access. No out_ready pulse. out_mem_wren/rden are 0 from the next cycle.
//  - FSM states: IDLE, MEM_RD, MEM_WR, DONE.
//  - Request decode (IDLE only; in_rd/in_wr are ignored when out_busy=1):
//      in_rd&in_wr both high -> illegal; DONE with out_err=1; no access; out_rdata unchanged.
//      addr in IO window, offset o = addr-IO_BASE:
//        read:  out_rdata <= inport capture reg[o] at the same edge, or 0 if o>=N_IN.
//        write: outport[o] <= in_wdata; out_outport_valid[o] pulses next cycle; dropped if o>=N_OUT.
//        both go to DONE. IO latency: request cycle 0 -> out_ready cycle 1.
//      otherwise read  -> MEM_RD; address/data registered at the sampling edge.
//      otherwise write -> MEM_WR; address/data registered at the sampling edge.
//  - MEM_RD: lasts MEM_LATENCY+1 cycles, counted by a 3-bit down-counter.
//      out_mem_rden=1 throughout. in_mem_q is captured into out_rdata at the edge ending the last MEM_RD cycle. Then DONE.
//      Read ready cycle = MEM_LATENCY+2 (ready in cycle 3 at default).
//  - MEM_WR: exactly one cycle with out_mem_wren=1, then DONE. Write ready in cycle 2.
//  - DONE: out_ready=1 for exactly one cycle, then IDLE. A new request is accepted in the cycle after DONE.
//  - Inport capture reg[k] <= in_inport_data[k] on any cycle in_inport_strobe[k]=1, independent of FSM state.
//      Strobe and IO read of the same channel in one cycle: the read returns the old value.
//  - out_rdata updates only on completed reads. Writes and errors leave it unchanged.
//  - out_mem_address/out_mem_data hold their last values while idle. rden/wren are 0 outside MEM_RD/MEM_WR.
// STRUCTURE
//  - Shared header mem_io_defs.vh: FSM state encodings, IO window size (16), default IO_BASE.
//  - Sub-module io_port_bank (params DATA_W, N_IN, N_OUT): inport capture regs, outport regs, valid pulses, offset mux.
//  - The top keeps the FSM, latency counter and RAM-side registers.
// TESTING
//  - Reset: assert reset for 2 cycles mid MEM_RD (L=1) -> no out_ready; rden=0 next cycle; all outputs 0.
//  - RAM read, L=1: preload addr 9'h010=32'hDEADBEEF; in_rd cycle 0 -> rden cycles 1-2, out_ready+rdata=DEADBEEF in cycle 3.
//  - RAM write then read: write 32'h12345678 to 9'h020 -> wren only in cycle 1, ready cycle 2; read back returns 12345678.
//  - IO: strobe inport1=32'hA5A5_0001; read 9'h1F1 -> ready cycle 1, rdata=A5A50001.
//      Write 32'h77 to 9'h1F0 -> outport0=77, valid[0] pulses once. Read 9'h1F5 -> rdata 0.
//  - Illegal and busy requests: in_rd&in_wr -> ready+err cycle 1, no rden/wren.
//      New in_rd while busy -> ignored, exactly one ready.
//  - Param sweep: MEM_LATENCY=3, N_IN=N_OUT=4 -> read ready cycle 5; write to 9'h1F3 updates only outport3.

Source files
------------

// File: rtl/mem_io_controller_pkg.sv
// rtl/mem_io_controller_pkg.sv - shared FSM encodings, IO window constants and request types
package mem_io_controller_pkg;

    // Controller FSM encodings
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_MEM_RD = 2'd1;
    localparam logic [1:0] ST_MEM_WR = 2'd2;
    localparam logic [1:0] ST_DONE   = 2'd3;

    // IO window: 16 consecutive words starting at IO_BASE
    localparam int IO_WIN_SIZE     = 16;
    localparam int IO_OFF_W        = 4;
    localparam int IO_BASE_DEFAULT = 'h1F0;

    // Classification of a request sampled in IDLE
    typedef enum logic [2:0] {
        REQ_NONE,
        REQ_ILLEGAL,
        REQ_IO_RD,
        REQ_IO_WR,
        REQ_MEM_RD,
        REQ_MEM_WR
    } req_kind_e;

endpackage

// File: rtl/mem_io_controller_if.sv
// rtl/mem_io_controller_if.sv - CPU-side request/response bus of the memory/IO controller
// Ports:
//   in_rd / in_wr      request strobes (MAR/MDR side)
//   in_addr / in_wdata request address and write data
//   out_rdata          read data, held until the next completed read
//   out_ready          one-cycle completion pulse
//   out_err            one-cycle pulse with out_ready on an illegal request
//   out_busy           controller not idle
// master = CPU datapath / control unit, slave = controller
interface mem_io_controller_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 9
);
    logic              in_rd;
    logic              in_wr;
    logic [ADDR_W-1:0] in_addr;
    logic [DATA_W-1:0] in_wdata;
    logic [DATA_W-1:0] out_rdata;
    logic              out_ready;
    logic              out_err;
    logic              out_busy;

    modport master (
        output in_rd, in_wr, in_addr, in_wdata,
        input  out_rdata, out_ready, out_err, out_busy
    );

    modport slave (
        input  in_rd, in_wr, in_addr, in_wdata,
        output out_rdata, out_ready, out_err, out_busy
    );
endinterface

// File: rtl/mem_io_controller_io_port_bank.sv
// rtl/mem_io_controller_io_port_bank.sv - inport capture registers, outport registers and IO read mux
// Ports:
//   clk, reset         system clock, synchronous active-high reset
//   in_inport_data     N_IN packed input words, channel k at [k*DATA_W +: DATA_W]
//   in_inport_strobe   per-channel capture enable, honoured in every cycle
//   rd_off / rd_data   IO read offset and selected capture register (0 past N_IN)
//   wr_en / wr_off     IO write strobe and offset (dropped past N_OUT)
//   wr_data            IO write data
//   out_outport_data   N_OUT packed output registers
//   out_outport_valid  one-cycle pulse the cycle after a channel is written
module io_port_bank
    import mem_io_controller_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int N_IN   = 2,
    parameter int N_OUT  = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [N_IN*DATA_W-1:0]  in_inport_data,
    input  logic [N_IN-1:0]         in_inport_strobe,
    input  logic [IO_OFF_W-1:0]     rd_off,
    output logic [DATA_W-1:0]       rd_data,
    input  logic                    wr_en,
    input  logic [IO_OFF_W-1:0]     wr_off,
    input  logic [DATA_W-1:0]       wr_data,
    output logic [N_OUT*DATA_W-1:0] out_outport_data,
    output logic [N_OUT-1:0]        out_outport_valid
);

    logic [DATA_W-1:0] cap [N_IN];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < N_IN; k++) begin
                cap[k] <= '0;
            end
        end else begin
            for (int k = 0; k < N_IN; k++) begin
                if (in_inport_strobe[k]) begin
                    cap[k] <= in_inport_data[k*DATA_W +: DATA_W];
                end
            end
        end
    end

    // Reads the registered value, so a same-cycle strobe is seen only by later reads
    always_comb begin
        rd_data = '0;
        for (int k = 0; k < N_IN; k++) begin
            if (rd_off == IO_OFF_W'(k)) begin
                rd_data = cap[k];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_outport_data  <= '0;
            out_outport_valid <= '0;
        end else begin
            out_outport_valid <= '0;
            for (int k = 0; k < N_OUT; k++) begin
                if (wr_en && (wr_off == IO_OFF_W'(k))) begin
                    out_outport_data[k*DATA_W +: DATA_W] <= wr_data;
                    out_outport_valid[k]                 <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/mem_io_controller.sv
// rtl/mem_io_controller.sv - memory/IO access controller between CPU MAR/MDR and the RAM macro
// Ports:
//   clk, reset         system clock, synchronous active-high reset
//   bus (slave)        CPU request/response bus, see mem_io_controller_if
//   out_mem_address    registered RAM address
//   out_mem_data       registered RAM write data
//   out_mem_rden       RAM read enable, high throughout MEM_RD
//   out_mem_wren       RAM write enable, high for the single MEM_WR cycle
//   in_mem_q           RAM read data, MEM_LATENCY clocks after the address
//   in_inport_data     N_IN packed external input words
//   in_inport_strobe   per-channel inport capture enable
//   out_outport_data   N_OUT packed output port registers
//   out_outport_valid  per-channel one-cycle write pulse
module mem_io_controller
    import mem_io_controller_pkg::*;
#(
    parameter int          DATA_W      = 32,
    parameter int          ADDR_W      = 9,
    parameter int          N_IN        = 2,
    parameter int          N_OUT       = 2,
    parameter int          MEM_LATENCY = 1,
    parameter int unsigned IO_BASE     = IO_BASE_DEFAULT
) (
    input  logic                    clk,
    input  logic                    reset,
    mem_io_controller_if.slave      bus,
    output logic [ADDR_W-1:0]       out_mem_address,
    output logic [DATA_W-1:0]       out_mem_data,
    output logic                    out_mem_rden,
    output logic                    out_mem_wren,
    input  logic [DATA_W-1:0]       in_mem_q,
    input  logic [N_IN*DATA_W-1:0]  in_inport_data,
    input  logic [N_IN-1:0]         in_inport_strobe,
    output logic [N_OUT*DATA_W-1:0] out_outport_data,
    output logic [N_OUT-1:0]        out_outport_valid
);

    localparam logic [ADDR_W-1:0] IO_BASE_A = ADDR_W'(IO_BASE);
    localparam logic [ADDR_W-1:0] IO_WIN_A  = ADDR_W'(IO_WIN_SIZE);
    localparam logic [2:0]        LAT_INIT  = 3'(MEM_LATENCY);

    logic [1:0]          state;
    logic [2:0]          lat_cnt;
    logic                err_q;
    logic [DATA_W-1:0]   rdata_q;
    req_kind_e           req_kind;
    logic [ADDR_W-1:0]   io_off_full;
    logic                in_io;
    logic [IO_OFF_W-1:0] io_off;
    logic [DATA_W-1:0]   io_rd_data;

    // Subtraction is only meaningful when addr >= IO_BASE; the range test
    // keeps the window correct even when IO_BASE+16 wraps the address space.
    assign io_off_full = bus.in_addr - IO_BASE_A;
    assign in_io       = (bus.in_addr >= IO_BASE_A) && (io_off_full < IO_WIN_A);
    assign io_off      = io_off_full[IO_OFF_W-1:0];

    always_comb begin
        req_kind = REQ_NONE;
        if (state == ST_IDLE) begin
            if (bus.in_rd && bus.in_wr) begin
                req_kind = REQ_ILLEGAL;
            end else if (bus.in_rd) begin
                req_kind = in_io ? REQ_IO_RD : REQ_MEM_RD;
            end else if (bus.in_wr) begin
                req_kind = in_io ? REQ_IO_WR : REQ_MEM_WR;
            end
        end
    end

    io_port_bank #(
        .DATA_W (DATA_W),
        .N_IN   (N_IN),
        .N_OUT  (N_OUT)
    ) u_port_bank (
        .clk               (clk),
        .reset             (reset),
        .in_inport_data    (in_inport_data),
        .in_inport_strobe  (in_inport_strobe),
        .rd_off            (io_off),
        .rd_data           (io_rd_data),
        .wr_en             (req_kind == REQ_IO_WR),
        .wr_off            (io_off),
        .wr_data           (bus.in_wdata),
        .out_outport_data  (out_outport_data),
        .out_outport_valid (out_outport_valid)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= ST_IDLE;
            lat_cnt         <= '0;
            err_q           <= 1'b0;
            rdata_q         <= '0;
            out_mem_address <= '0;
            out_mem_data    <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    err_q <= 1'b0;
                    case (req_kind)
                        REQ_ILLEGAL: begin
                            err_q <= 1'b1;
                            state <= ST_DONE;
                        end
                        REQ_IO_RD: begin
                            rdata_q <= io_rd_data;
                            state   <= ST_DONE;
                        end
                        REQ_IO_WR: begin
                            state <= ST_DONE;
                        end
                        REQ_MEM_RD: begin
                            out_mem_address <= bus.in_addr;
                            out_mem_data    <= bus.in_wdata;
                            lat_cnt         <= LAT_INIT;
                            state           <= ST_MEM_RD;
                        end
                        REQ_MEM_WR: begin
                            out_mem_address <= bus.in_addr;
                            out_mem_data    <= bus.in_wdata;
                            state           <= ST_MEM_WR;
                        end
                        default: ;
                    endcase
                end
                // Counter starts at MEM_LATENCY and ends at 0, giving MEM_LATENCY+1 cycles
                ST_MEM_RD: begin
                    if (lat_cnt == 3'd0) begin
                        rdata_q <= in_mem_q;
                        state   <= ST_DONE;
                    end else begin
                        lat_cnt <= lat_cnt - 3'd1;
                    end
                end
                ST_MEM_WR: begin
                    state <= ST_DONE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign out_mem_rden  = (state == ST_MEM_RD);
    assign out_mem_wren  = (state == ST_MEM_WR);
    assign bus.out_ready = (state == ST_DONE);
    assign bus.out_err   = (state == ST_DONE) && err_q;
    assign bus.out_busy  = (state != ST_IDLE);
    assign bus.out_rdata = rdata_q;

endmodule

// File: tb/tb_mem_io_controller.sv
// tb/tb_mem_io_controller.sv - self-checking bench for mem_io_controller (default and L=3/4-port instances)
module tb_mem_io_controller;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    mem_io_controller_if #(.DATA_W(32), .ADDR_W(9)) bus0 ();
    mem_io_controller_if #(.DATA_W(32), .ADDR_W(9)) bus1 ();

    logic        sel = 1'b0;
    logic        rd = 1'b0, wr = 1'b0;
    logic [8:0]  addr = '0;
    logic [31:0] wdata = '0;

    assign bus0.in_rd    = rd & ~sel;
    assign bus0.in_wr    = wr & ~sel;
    assign bus0.in_addr  = addr;
    assign bus0.in_wdata = wdata;
    assign bus1.in_rd    = rd & sel;
    assign bus1.in_wr    = wr & sel;
    assign bus1.in_addr  = addr;
    assign bus1.in_wdata = wdata;

    logic [8:0]   m0_addr, m1_addr;
    logic [31:0]  m0_data, m1_data, m0_q, m1_q;
    logic         m0_rden, m0_wren, m1_rden, m1_wren;
    logic [63:0]  inport0 = '0, outport0;
    logic [127:0] inport1 = '0, outport1;
    logic [1:0]   strobe0 = '0, valid0;
    logic [3:0]   strobe1 = '0, valid1;

    mem_io_controller #(.DATA_W(32), .ADDR_W(9), .N_IN(2), .N_OUT(2), .MEM_LATENCY(1), .IO_BASE('h1F0)) u0 (
        .clk(clk), .reset(reset), .bus(bus0),
        .out_mem_address(m0_addr), .out_mem_data(m0_data), .out_mem_rden(m0_rden), .out_mem_wren(m0_wren),
        .in_mem_q(m0_q), .in_inport_data(inport0), .in_inport_strobe(strobe0),
        .out_outport_data(outport0), .out_outport_valid(valid0)
    );

    mem_io_controller #(.DATA_W(32), .ADDR_W(9), .N_IN(4), .N_OUT(4), .MEM_LATENCY(3), .IO_BASE('h1F0)) u1 (
        .clk(clk), .reset(reset), .bus(bus1),
        .out_mem_address(m1_addr), .out_mem_data(m1_data), .out_mem_rden(m1_rden), .out_mem_wren(m1_wren),
        .in_mem_q(m1_q), .in_inport_data(inport1), .in_inport_strobe(strobe1),
        .out_outport_data(outport1), .out_outport_valid(valid1)
    );

    // RAM macros: latency 1 for u0, latency 3 for u1; a preload port fills them at start
    logic [31:0] ram0 [512];
    logic [31:0] ram1 [512];
    logic [31:0] r1_p0, r1_p1;
    logic        pl_en = 1'b0;
    logic [8:0]  pl_addr = '0;
    logic [31:0] pl_d0 = '0, pl_d1 = '0;

    always @(posedge clk) begin
        if (pl_en) begin
            ram0[pl_addr] <= pl_d0;
            ram1[pl_addr] <= pl_d1;
        end else begin
            if (m0_wren) ram0[m0_addr] <= m0_data;
            if (m1_wren) ram1[m1_addr] <= m1_data;
        end
        m0_q  <= ram0[m0_addr];
        r1_p0 <= ram1[m1_addr];
        r1_p1 <= r1_p0;
        m1_q  <= r1_p1;
    end

    typedef struct {
        logic s; logic r; logic w; logic hold;
        logic [8:0] a; logic [31:0] d; logic [3:0] stm; logic [31:0] std;
        int cyc; logic [31:0] rdata; logic err; int rden; int wren; logic [3:0] vmask;
    } vec_t;

    typedef struct {
        int cyc; logic [31:0] rdata; logic err; int rden; int wren;
        logic [3:0] vmask; int vextra; int nready; int nbusy;
    } res_t;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: spec-level view of memories, ports and last read data
    logic [31:0] mdl_mem   [2][512];
    logic [31:0] mdl_in    [2][4];
    logic [31:0] mdl_out   [2][4];
    logic [31:0] mdl_rdata [2];
    int          lat [2] = '{1, 3};
    int          nch [2] = '{2, 4};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic s, input logic r, input logic w, input logic hold,
                                input logic [8:0] a, input logic [31:0] d, input logic [3:0] stm,
                                input logic [31:0] std, input int cyc, input logic [31:0] rdata,
                                input logic err, input int rden, input int wren, input logic [3:0] vmask);
        vec_t v;
        v.s = s; v.r = r; v.w = w; v.hold = hold; v.a = a; v.d = d; v.stm = stm; v.std = std;
        v.cyc = cyc; v.rdata = rdata; v.err = err; v.rden = rden; v.wren = wren; v.vmask = vmask;
        return v;
    endfunction

    // Fills expected fields of v from the model and advances the model
    task automatic model_step(inout vec_t v);
        int s, o;
        s = v.s ? 1 : 0;
        v.err = 1'b0; v.rden = 0; v.wren = 0; v.vmask = '0;
        if (v.r && v.w) begin
            v.cyc = 1; v.err = 1'b1;
        end else if (v.a >= 9'h1F0) begin
            o = int'(v.a) - 'h1F0;
            v.cyc = 1;
            if (v.r) mdl_rdata[s] = (o < nch[s]) ? mdl_in[s][o] : 32'h0;
            else if (o < nch[s]) begin
                mdl_out[s][o] = v.d;
                v.vmask = 4'(1 << o);
            end
        end else if (v.r) begin
            v.cyc = lat[s] + 2; v.rden = lat[s] + 1;
            mdl_rdata[s] = mdl_mem[s][v.a];
        end else begin
            v.cyc = 2; v.wren = 1;
            mdl_mem[s][v.a] = v.d;
        end
        v.rdata = mdl_rdata[s];
        for (int k = 0; k < nch[s]; k++) if (v.stm[k]) mdl_in[s][k] = v.std;
    endtask

    task automatic do_req(input vec_t v, output res_t q);
        int n;
        logic rdy, busy, rden, wren, err;
        logic [31:0] rdat;
        logic [3:0] vb;
        q.cyc = 0; q.rdata = '0; q.err = 1'b0; q.rden = 0; q.wren = 0;
        q.vmask = '0; q.vextra = 0; q.nready = 0; q.nbusy = 0;
        @(negedge clk);
        sel = v.s; rd = v.r; wr = v.w; addr = v.a; wdata = v.d;
        if (!v.s) begin strobe0 = v.stm[1:0]; inport0 = {2{v.std}}; end
        else      begin strobe1 = v.stm;      inport1 = {4{v.std}}; end
        n = 0;
        while (n < 12 && !(q.cyc != 0 && n >= q.cyc + 2)) begin
            @(negedge clk);
            n++;
            if (n == 1) begin
                strobe0 = '0; strobe1 = '0;
                if (!v.hold) begin rd = 1'b0; wr = 1'b0; end
            end
            if (!v.s) begin
                rdy = bus0.out_ready; busy = bus0.out_busy; err = bus0.out_err; rdat = bus0.out_rdata;
                rden = m0_rden; wren = m0_wren; vb = {2'b00, valid0};
            end else begin
                rdy = bus1.out_ready; busy = bus1.out_busy; err = bus1.out_err; rdat = bus1.out_rdata;
                rden = m1_rden; wren = m1_wren; vb = valid1;
            end
            if (rdy) begin
                q.nready++;
                if (q.cyc == 0) begin q.cyc = n; q.rdata = rdat; q.err = err; end
                rd = 1'b0; wr = 1'b0;
            end else if (err) begin
                q.err = 1'b1;
            end
            if (busy) q.nbusy++;
            if (rden) q.rden++;
            if (wren) q.wren++;
            if (n == 1) q.vmask = vb;
            else q.vextra += $countones(vb);
        end
        rd = 1'b0; wr = 1'b0;
    endtask

    task automatic check_txn(input string tag, input vec_t e, input res_t q);
        chk({tag, ".ready_cycle"}, q.cyc, e.cyc);
        chk({tag, ".rdata"}, q.rdata, e.rdata);
        chk({tag, ".err"}, q.err, e.err);
        chk({tag, ".rden_cycles"}, q.rden, e.rden);
        chk({tag, ".wren_cycles"}, q.wren, e.wren);
        chk({tag, ".valid_mask"}, q.vmask, e.vmask);
        chk({tag, ".valid_extra"}, q.vextra, 0);
        chk({tag, ".ready_count"}, q.nready, 1);
        chk({tag, ".busy_cycles"}, q.nbusy, e.cyc);
    endtask

    vec_t tbl[$];

    initial begin
        vec_t v;
        res_t q;
        int kind, s;
        int cnt;

        for (int i = 0; i < 2; i++) begin
            mdl_rdata[i] = '0;
            for (int k = 0; k < 4; k++) begin mdl_in[i][k] = '0; mdl_out[i][k] = '0; end
            for (int a = 0; a < 512; a++) mdl_mem[i][a] = $urandom;
        end
        mdl_mem[0][9'h010] = 32'hDEADBEEF;
        mdl_mem[1][9'h010] = 32'hCAFEF00D;

        repeat (3) @(negedge clk);
        chk("reset.rdata0", bus0.out_rdata, 32'h0);
        chk("reset.ready0", bus0.out_ready, 1'b0);
        chk("reset.err0", bus0.out_err, 1'b0);
        chk("reset.busy0", bus0.out_busy, 1'b0);
        chk("reset.rden0", m0_rden, 1'b0);
        chk("reset.wren0", m0_wren, 1'b0);
        chk("reset.mem_addr0", m0_addr, 9'h0);
        chk("reset.mem_data0", m0_data, 32'h0);
        chk("reset.outport0", outport0[31:0] | outport0[63:32], 32'h0);
        chk("reset.valid0", valid0, 2'b00);
        chk("reset.busy1", bus1.out_busy, 1'b0);
        chk("reset.valid1", valid1, 4'h0);

        for (int a = 0; a < 512; a++) begin
            @(negedge clk);
            pl_en = 1'b1; pl_addr = 9'(a); pl_d0 = mdl_mem[0][a]; pl_d1 = mdl_mem[1][a];
        end
        @(negedge clk);
        pl_en = 1'b0;
        reset = 1'b0;

        @(negedge clk);
        strobe0 = 2'b10; inport0 = {32'hA5A50001, 32'h0};
        @(negedge clk);
        strobe0 = 2'b00;
        mdl_in[0][1] = 32'hA5A50001;

        //          s     r     w     hold  addr    wdata         stm   std           cyc rdata         err   rden wren vmask
        tbl.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 9'h010, 32'h0,        4'h0, 32'h0,        3, 32'hDEADBEEF, 1'b0, 2, 0, 4'h0));
        tbl.push_back(mk(1'b0, 1'b0, 1'b1, 1'b0, 9'h020, 32'h12345678, 4'h0, 32'h0,        2, 32'hDEADBEEF, 1'b0, 0, 1, 4'h0));
        tbl.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 9'h020, 32'h0,        4'h0, 32'h0,        3, 32'h12345678, 1'b0, 2, 0, 4'h0));
        tbl.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 9'h1F1, 32'h0,        4'h0, 32'h0,        1, 32'hA5A50001, 1'b0, 0, 0, 4'h0));
        tbl.push_back(mk(1'b0, 1'b0, 1'b1, 1'b0, 9'h1F0, 32'h77,       4'h0, 32'h0,        1, 32'hA5A50001, 1'b0, 0, 0, 4'h1));
        tbl.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 9'h1F5, 32'h0,        4'h0, 32'h0,        1, 32'h0,        1'b0, 0, 0, 4'h0));
        tbl.push_back(mk(1'b0, 1'b0, 1'b1, 1'b0, 9'h1F3, 32'hBAD,      4'h0, 32'h0,        1, 32'h0,        1'b0, 0, 0, 4'h0));
        tbl.push_back(mk(1'b0, 1'b1, 1'b1, 1'b0, 9'h010, 32'h0,        4'h0, 32'h0,        1, 32'h0,        1'b1, 0, 0, 4'h0));
        tbl.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 9'h1F1, 32'h0,        4'h2, 32'h11112222, 1, 32'hA5A50001, 1'b0, 0, 0, 4'h0));
        tbl.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 9'h1F1, 32'h0,        4'h0, 32'h0,        1, 32'h11112222, 1'b0, 0, 0, 4'h0));
        tbl.push_back(mk(1'b0, 1'b1, 1'b0, 1'b1, 9'h010, 32'h0,        4'h0, 32'h0,        3, 32'hDEADBEEF, 1'b0, 2, 0, 4'h0));
        tbl.push_back(mk(1'b1, 1'b1, 1'b0, 1'b0, 9'h010, 32'h0,        4'h0, 32'h0,        5, 32'hCAFEF00D, 1'b0, 4, 0, 4'h0));
        tbl.push_back(mk(1'b1, 1'b0, 1'b1, 1'b0, 9'h1F3, 32'hBEEF0003, 4'h0, 32'h0,        1, 32'hCAFEF00D, 1'b0, 0, 0, 4'h8));
        tbl.push_back(mk(1'b1, 1'b0, 1'b1, 1'b0, 9'h040, 32'h5555AAAA, 4'h0, 32'h0,        2, 32'hCAFEF00D, 1'b0, 0, 1, 4'h0));
        tbl.push_back(mk(1'b1, 1'b1, 1'b0, 1'b0, 9'h040, 32'h0,        4'h0, 32'h0,        5, 32'h5555AAAA, 1'b0, 4, 0, 4'h0));
        tbl.push_back(mk(1'b1, 1'b1, 1'b1, 1'b0, 9'h1F0, 32'h0,        4'h0, 32'h0,        1, 32'h5555AAAA, 1'b1, 0, 0, 4'h0));

        foreach (tbl[i]) begin
            v = tbl[i];
            do_req(v, q);
            check_txn($sformatf("row%0d", i), tbl[i], q);
            model_step(v);
        end

        chk("tbl.outport0_ch0", outport0[31:0], 32'h77);
        chk("tbl.outport0_ch1", outport0[63:32], 32'h0);
        chk("tbl.outport1_ch3", outport1[127:96], 32'hBEEF0003);
        chk("tbl.outport1_ch0to2", outport1[31:0] | outport1[63:32] | outport1[95:64], 32'h0);

        for (int t = 0; t < 80; t++) begin
            s = int'($urandom_range(0, 1));
            kind = int'($urandom_range(0, 5));
            v = mk(s[0], 1'b0, 1'b0, 1'($urandom_range(0, 1)), 9'h0, $urandom, 4'h0, $urandom,
                   0, 32'h0, 1'b0, 0, 0, 4'h0);
            case (kind)
                0, 5: begin v.r = 1'b1; v.a = 9'($urandom_range(0, 'h1EF)); end
                1:    begin v.w = 1'b1; v.a = 9'($urandom_range(0, 'h1EF)); end
                2:    begin v.r = 1'b1; v.a = 9'($urandom_range('h1F0, 'h1FF)); end
                3:    begin v.w = 1'b1; v.a = 9'($urandom_range('h1F0, 'h1FF)); end
                default: begin v.r = 1'b1; v.w = 1'b1; v.a = 9'($urandom_range(0, 'h1FF)); end
            endcase
            if ($urandom_range(0, 2) == 0) v.stm = 4'($urandom_range(0, 15)) & (s ? 4'hF : 4'h3);
            model_step(v);
            do_req(v, q);
            check_txn($sformatf("rnd%0d", t), v, q);
        end

        for (int k = 0; k < 2; k++) chk($sformatf("rnd.outport0_ch%0d", k), outport0[k*32 +: 32], mdl_out[0][k]);
        for (int k = 0; k < 4; k++) chk($sformatf("rnd.outport1_ch%0d", k), outport1[k*32 +: 32], mdl_out[1][k]);

        // Reset asserted for two cycles in the middle of a latency-1 RAM read
        @(negedge clk);
        sel = 1'b0; rd = 1'b1; addr = 9'h010;
        @(negedge clk);
        rd = 1'b0;
        chk("rst_mid.rden_before", m0_rden, 1'b1);
        reset = 1'b1;
        @(negedge clk);
        chk("rst_mid.rden", m0_rden, 1'b0);
        chk("rst_mid.ready", bus0.out_ready, 1'b0);
        chk("rst_mid.busy", bus0.out_busy, 1'b0);
        chk("rst_mid.rdata", bus0.out_rdata, 32'h0);
        chk("rst_mid.mem_addr", m0_addr, 9'h0);
        chk("rst_mid.outport0", outport0[31:0] | outport0[63:32], 32'h0);
        @(negedge clk);
        reset = 1'b0;
        cnt = 0;
        repeat (6) begin
            @(negedge clk);
            if (bus0.out_ready) cnt++;
        end
        chk("rst_mid.no_ready", cnt, 0);

        v = mk(1'b0, 1'b1, 1'b0, 1'b0, 9'h1F1, 32'h0, 4'h0, 32'h0, 1, 32'h0, 1'b0, 0, 0, 4'h0);
        do_req(v, q);
        check_txn("rst_mid.inport_cleared", v, q);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
